// File: rtl/button_debouncer.sv
// Debounces one raw push-button pad into a clean level plus one-cycle press/release pulses.
// Two-flop synchronizer feeds a four-state FSM that needs DEBOUNCE_CYCLES+1 stable samples.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_raw,
    output logic button_db,
    output logic button_press,
    output logic button_release
);

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StPressed,
        StReleaseWait
    } state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             s1_q;
    logic             s2_q;
    logic             cnt_done;

    assign cnt_done = (cnt_q == CntLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= button_raw;
            s2_q <= s1_q;
        end
    end

    // Counter is cleared on every state entry, so any reversal restarts the full window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            button_db      <= 1'b0;
            button_press   <= 1'b0;
            button_release <= 1'b0;
        end else begin
            button_press   <= 1'b0;
            button_release <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (s2_q) begin
                        state_q <= StPressWait;
                        cnt_q   <= '0;
                    end
                end
                StPressWait: begin
                    if (!s2_q) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (cnt_done) begin
                        state_q      <= StPressed;
                        cnt_q        <= '0;
                        button_db    <= 1'b1;
                        button_press <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StPressed: begin
                    if (!s2_q) begin
                        state_q <= StReleaseWait;
                        cnt_q   <= '0;
                    end
                end
                StReleaseWait: begin
                    if (s2_q) begin
                        state_q <= StPressed;
                        cnt_q   <= '0;
                    end else if (cnt_done) begin
                        state_q        <= StIdle;
                        cnt_q          <= '0;
                        button_db      <= 1'b0;
                        button_release <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: tasks push expected pulses with their edge number,
// a negedge monitor records observed pulses, and each task compares the two queues.
module tb_button_debouncer;

    localparam int unsigned Deb = 8;
    localparam int          Lat = Deb + 3;

    typedef struct packed {
        logic press;
        int   edge_n;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    logic button_raw;
    logic button_db;
    logic button_press;
    logic button_release;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_pass = 0;
    int  obs_rd = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];

    button_debouncer #(
        .DEBOUNCE_CYCLES(Deb),
        .CNT_W          (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .button_raw    (button_raw),
        .button_db     (button_db),
        .button_press  (button_press),
        .button_release(button_release)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (button_press === 1'b1) obs_q.push_back('{press: 1'b1, edge_n: cyc});
        if (button_release === 1'b1) obs_q.push_back('{press: 1'b0, edge_n: cyc});
    end

    function automatic string ev_name(input logic p);
        return p ? "press" : "release";
    endfunction

    task automatic test_reset();
        rst_n      = 1'b0;
        button_raw = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (button_db !== 1'b0) $display("FAIL reset_db: got %b, required 0", button_db);
        else n_pass++;
        n_checks++;
        if (button_press !== 1'b0) $display("FAIL reset_press: got %b, required 0", button_press);
        else n_pass++;
        n_checks++;
        if (button_release !== 1'b0)
            $display("FAIL reset_release: got %b, required 0", button_release);
        else n_pass++;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_clean_press();
        int  t0;
        ev_t o, e;
        @(posedge clk);
        #1;
        button_raw = 1'b1;
        t0 = cyc;
        exp_q.push_back('{press: 1'b1, edge_n: t0 + Lat});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (button_db !== logic'(cyc >= t0 + Lat))
                $display("FAIL clean_press_db at edge %0d: got %b, required %b",
                         cyc, button_db, cyc >= t0 + Lat);
            else n_pass++;
        end
        #1;
        while (obs_rd < obs_q.size()) begin
            o = obs_q[obs_rd];
            obs_rd++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL clean_press_pulse: got %s at edge %0d, required none",
                         ev_name(o.press), o.edge_n);
            end else begin
                e = exp_q.pop_front();
                if (o !== e)
                    $display("FAIL clean_press_pulse: got %s at edge %0d, required %s at edge %0d",
                             ev_name(o.press), o.edge_n, ev_name(e.press), e.edge_n);
                else n_pass++;
            end
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            $display("FAIL clean_press_pulse: got none, required %s at edge %0d",
                     ev_name(e.press), e.edge_n);
        end
    endtask

    task automatic test_release();
        int  t0;
        ev_t o, e;
        @(posedge clk);
        #1;
        button_raw = 1'b0;
        t0 = cyc;
        exp_q.push_back('{press: 1'b0, edge_n: t0 + Lat});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (button_db !== logic'(cyc < t0 + Lat))
                $display("FAIL release_db at edge %0d: got %b, required %b",
                         cyc, button_db, cyc < t0 + Lat);
            else n_pass++;
        end
        #1;
        while (obs_rd < obs_q.size()) begin
            o = obs_q[obs_rd];
            obs_rd++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL release_pulse: got %s at edge %0d, required none",
                         ev_name(o.press), o.edge_n);
            end else begin
                e = exp_q.pop_front();
                if (o !== e)
                    $display("FAIL release_pulse: got %s at edge %0d, required %s at edge %0d",
                             ev_name(o.press), o.edge_n, ev_name(e.press), e.edge_n);
                else n_pass++;
            end
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            $display("FAIL release_pulse: got none, required %s at edge %0d",
                     ev_name(e.press), e.edge_n);
        end
    endtask

    // Raw toggles 1,0,1,0 every 3 cycles, then settles high on iteration 12.
    task automatic test_bouncy_press();
        int   t_final;
        logic exp_db;
        ev_t  o, e;
        t_final = 0;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #1;
            button_raw = (i >= 12) ? 1'b1 : logic'(((i / 3) % 2) == 0);
            if (i == 12) begin
                t_final = cyc;
                exp_q.push_back('{press: 1'b1, edge_n: t_final + Lat});
            end
            @(negedge clk);
            exp_db = (i >= 12) && (cyc >= t_final + Lat);
            n_checks++;
            if (button_db !== exp_db)
                $display("FAIL bouncy_db at edge %0d: got %b, required %b", cyc, button_db, exp_db);
            else n_pass++;
        end
        #1;
        while (obs_rd < obs_q.size()) begin
            o = obs_q[obs_rd];
            obs_rd++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL bouncy_pulse: got %s at edge %0d, required none",
                         ev_name(o.press), o.edge_n);
            end else begin
                e = exp_q.pop_front();
                if (o !== e)
                    $display("FAIL bouncy_pulse: got %s at edge %0d, required %s at edge %0d",
                             ev_name(o.press), o.edge_n, ev_name(e.press), e.edge_n);
                else n_pass++;
            end
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            $display("FAIL bouncy_pulse: got none, required %s at edge %0d",
                     ev_name(e.press), e.edge_n);
        end
    endtask

    task automatic test_release_glitch();
        ev_t o;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            button_raw = (i >= 5) ? 1'b1 : 1'b0;
            @(negedge clk);
            n_checks++;
            if (button_db !== 1'b1)
                $display("FAIL release_glitch_db at edge %0d: got %b, required 1", cyc, button_db);
            else n_pass++;
        end
        #1;
        while (obs_rd < obs_q.size()) begin
            o = obs_q[obs_rd];
            obs_rd++;
            n_checks++;
            $display("FAIL release_glitch_pulse: got %s at edge %0d, required none",
                     ev_name(o.press), o.edge_n);
        end
    endtask

    // Reset lands between clock edges while PRESSED; outputs must clear without a clock edge.
    task automatic test_async_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if (button_db !== 1'b1) $display("FAIL async_reset_pre_db: got %b, required 1", button_db);
        else n_pass++;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (button_db !== 1'b0) $display("FAIL async_reset_db: got %b, required 0", button_db);
        else n_pass++;
        n_checks++;
        if ((button_press | button_release) !== 1'b0)
            $display("FAIL async_reset_pulses: got %b%b, required 00", button_press, button_release);
        else n_pass++;
        button_raw = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_reset_mid_window();
        int  r0;
        int  t0;
        ev_t o, e;
        @(posedge clk);
        #1;
        button_raw = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (button_db !== 1'b0) $display("FAIL mid_window_reset_db: got %b, required 0", button_db);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        r0 = cyc;
        exp_q.push_back('{press: 1'b1, edge_n: r0 + Lat});
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_checks++;
            if (button_db !== logic'(cyc >= r0 + Lat))
                $display("FAIL mid_window_db at edge %0d: got %b, required %b",
                         cyc, button_db, cyc >= r0 + Lat);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        button_raw = 1'b0;
        t0 = cyc;
        exp_q.push_back('{press: 1'b0, edge_n: t0 + Lat});
        repeat (16) @(negedge clk);
        #1;
        while (obs_rd < obs_q.size()) begin
            o = obs_q[obs_rd];
            obs_rd++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL mid_window_pulse: got %s at edge %0d, required none",
                         ev_name(o.press), o.edge_n);
            end else begin
                e = exp_q.pop_front();
                if (o !== e)
                    $display("FAIL mid_window_pulse: got %s at edge %0d, required %s at edge %0d",
                             ev_name(o.press), o.edge_n, ev_name(e.press), e.edge_n);
                else n_pass++;
            end
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            $display("FAIL mid_window_pulse: got none, required %s at edge %0d",
                     ev_name(e.press), e.edge_n);
        end
    endtask

    // An 8-cycle high pulse is one sample short; a 9-cycle pulse is the shortest accepted.
    task automatic test_glitch();
        int   t0;
        logic exp_db;
        ev_t  o, e;
        t0 = 0;
        for (int i = 0; i < 52; i++) begin
            @(posedge clk);
            #1;
            button_raw = (i < 8) || (i >= 20 && i < 29);
            if (i == 0) t0 = cyc;
            if (i == 20) exp_q.push_back('{press: 1'b1, edge_n: cyc + Lat});
            if (i == 29) exp_q.push_back('{press: 1'b0, edge_n: cyc + Lat});
            @(negedge clk);
            exp_db = (cyc >= t0 + 20 + Lat) && (cyc < t0 + 29 + Lat);
            n_checks++;
            if (button_db !== exp_db)
                $display("FAIL glitch_db at edge %0d: got %b, required %b", cyc, button_db, exp_db);
            else n_pass++;
        end
        #1;
        while (obs_rd < obs_q.size()) begin
            o = obs_q[obs_rd];
            obs_rd++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL glitch_pulse: got %s at edge %0d, required none",
                         ev_name(o.press), o.edge_n);
            end else begin
                e = exp_q.pop_front();
                if (o !== e)
                    $display("FAIL glitch_pulse: got %s at edge %0d, required %s at edge %0d",
                             ev_name(o.press), o.edge_n, ev_name(e.press), e.edge_n);
                else n_pass++;
            end
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            $display("FAIL glitch_pulse: got none, required %s at edge %0d",
                     ev_name(e.press), e.edge_n);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release();
        test_bouncy_press();
        test_release_glitch();
        test_async_reset();
        test_reset_mid_window();
        test_glitch();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
